// File: rtl/ifm_skew_buffer.sv
// IFM skew buffer: delays lane i of each RAM read word by i cycles for the systolic array west edge.
// Define IFM_SKEW_LANE_MASK_EN to zero lanes at or beyond the latched tile width (read_ifm_size).
module ifm_skew_buffer #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int RAM_LATENCY   = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                read_en,
  input  logic [4:0]                          read_ifm_size,
  input  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] ifm_rdata,
  output logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] ifm_skew_data,
  output logic [SYSTOLIC_SIZE-1:0]            ifm_skew_valid,
  output logic                                busy,
  output logic                                done
);

  localparam int S  = SYSTOLIC_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int RL = RAM_LATENCY;
  localparam int CW = $clog2(S) + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   drainCnt_q, drainCnt_d;
  logic [RL-1:0]   rdPipe_q;
  logic [RL:0]     rdTap;
  logic            inValid;
  logic            earlyValid;
  logic [S-1:0]    laneMask;
  logic [S-1:0]    vld_q;

  // rdTap[k] is read_en delayed k cycles; the top tap is the RAM data valid
  assign rdTap      = {rdPipe_q, read_en};
  assign inValid    = rdTap[RL];
  assign earlyValid = rdTap[RL-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPipe_q <= '0;
      vld_q    <= '0;
    end else begin
      rdPipe_q <= rdTap[RL-1:0];
      vld_q    <= {vld_q[S-2:0], inValid};
    end
  end

  assign ifm_skew_valid = vld_q;

`ifdef IFM_SKEW_LANE_MASK_EN
  logic [CW-1:0] sizeHold_q, sizeCur, inSize;
  logic [CW-1:0] sizePipe_q [RL];
  logic          readRise;

  // Size is sampled only on the first read of a burst, then rides along with the data
  assign readRise = read_en & ~rdTap[1];

  always_comb begin
    sizeCur = sizeHold_q;
    if (readRise) begin
      if (read_ifm_size == '0 || int'(read_ifm_size) > S) sizeCur = CW'(S);
      else sizeCur = CW'(read_ifm_size);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sizeHold_q <= '0;
      for (int k = 0; k < RL; k++) sizePipe_q[k] <= '0;
    end else begin
      sizeHold_q    <= sizeCur;
      sizePipe_q[0] <= sizeCur;
      for (int k = 1; k < RL; k++) sizePipe_q[k] <= sizePipe_q[k-1];
    end
  end

  assign inSize = sizePipe_q[RL-1];

  always_comb begin
    laneMask = '0;
    for (int i = 0; i < S; i++) laneMask[i] = (i < int'(inSize));
  end
`else
  logic unusedSize;
  assign unusedSize = ^read_ifm_size;
  assign laneMask   = '1;
`endif

  // Lane i: one gated input register followed by i plain delay registers
  for (genvar i = 0; i < S; i++) begin : g_lane
    logic [DW-1:0] dly_q [i+1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= i; k++) dly_q[k] <= '0;
      end else begin
        dly_q[0] <= (inValid && laneMask[i]) ? ifm_rdata[i*DW +: DW] : '0;
        for (int k = 1; k <= i; k++) dly_q[k] <= dly_q[k-1];
      end
    end

    assign ifm_skew_data[i*DW +: DW] = dly_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      drainCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      drainCnt_q <= drainCnt_d;
    end
  end

  // The FSM watches the tap one cycle ahead of inValid so that busy rises with the
  // first valid input beat and done lands on the cycle the last beat leaves lane S-1.
  always_comb begin
    state_d    = state_q;
    drainCnt_d = drainCnt_q;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (earlyValid) state_d = STREAM;
      end
      STREAM: begin
        if (!earlyValid) begin
          state_d    = DRAIN;
          drainCnt_d = '0;
        end
      end
      DRAIN: begin
        drainCnt_d = drainCnt_q + 1'b1;
        if (drainCnt_q == CW'(S-1)) begin
          done    = 1'b1;
          state_d = IDLE;
        end
        if (earlyValid) state_d = STREAM;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_ifm_skew_buffer.sv
// Directed self-checking bench for ifm_skew_buffer; expected lane values, valid, busy and done
// are derived from the per-cycle read plan (read at cycle s shows on lane i at cycle s+RL+1+i).
module tb_ifm_skew_buffer;

  localparam int S    = 16;
  localparam int DW   = 16;
  localparam int RL   = 1;
  localparam int MAXC = 64;

`ifdef IFM_SKEW_LANE_MASK_EN
  localparam bit MASK_ON = 1'b1;
`else
  localparam bit MASK_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              read_en;
  logic [4:0]        read_ifm_size;
  logic [S*DW-1:0]   ifm_rdata;
  logic [S*DW-1:0]   ifm_skew_data;
  logic [S-1:0]      ifm_skew_valid;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  bit planRe   [MAXC];
  int planSize [MAXC];
  bit allOnes;

  ifm_skew_buffer #(
    .SYSTOLIC_SIZE(S),
    .DATA_WIDTH(DW),
    .RAM_LATENCY(RL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .read_en(read_en),
    .read_ifm_size(read_ifm_size),
    .ifm_rdata(ifm_rdata),
    .ifm_skew_data(ifm_skew_data),
    .ifm_skew_valid(ifm_skew_valid),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [S*DW-1:0] got, input logic [S*DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  function automatic int effSize(input int sz);
    return (sz == 0 || sz > S) ? S : sz;
  endfunction

  function automatic logic [DW-1:0] pattern(input int s, input int i);
    return allOnes ? {DW{1'b1}} : DW'((i << 8) + s);
  endfunction

  function automatic logic [S*DW-1:0] rdataFor(input int s);
    logic [S*DW-1:0] r;
    r = '0;
    for (int i = 0; i < S; i++) r[i*DW +: DW] = pattern(s, i);
    return r;
  endfunction

  task automatic clearPlan();
    for (int k = 0; k < MAXC; k++) begin
      planRe[k]   = 1'b0;
      planSize[k] = 0;
    end
  endtask

  task automatic setBurst(input int start, input int n, input int size);
    for (int k = start; k < start + n; k++) begin
      planRe[k]   = 1'b1;
      planSize[k] = size;
    end
  endtask

  // Plays both the address controller (read_en/size) and the RAM (data RL cycles later)
  task automatic applyStimulus(input int c);
    read_en       = planRe[c];
    read_ifm_size = 5'(planSize[c]);
    if (c >= RL && planRe[c-RL]) ifm_rdata = rdataFor(c - RL);
    else ifm_rdata = {S{16'hDEAD}};
  endtask

  task automatic runPlan(input string name, input int nCycles);
    logic [S*DW-1:0] expData;
    logic [S-1:0]    expValid;
    logic            expBusy, expDone, later;
    int              s, s0;
    for (int c = 0; c < nCycles; c++) begin
      applyStimulus(c);
      expData  = '0;
      expValid = '0;
      for (int i = 0; i < S; i++) begin
        s = c - RL - 1 - i;
        if (s >= 0 && planRe[s]) begin
          expValid[i] = 1'b1;
          if (!MASK_ON || i < effSize(planSize[s])) expData[i*DW +: DW] = pattern(s, i);
        end
      end
      expBusy = 1'b0;
      for (int k = c - RL - S; k <= c - RL; k++)
        if (k >= 0 && planRe[k]) expBusy = 1'b1;
      s0 = c - RL - S;
      later = 1'b0;
      for (int k = s0 + 1; k <= c - RL; k++)
        if (k >= 0 && planRe[k]) later = 1'b1;
      expDone = (s0 >= 0) && planRe[s0] && !later;
      checkOutput($sformatf("%s c%0d data", name, c), ifm_skew_data, expData);
      checkOutput($sformatf("%s c%0d valid", name, c), {{(S*DW-S){1'b0}}, ifm_skew_valid}, {{(S*DW-S){1'b0}}, expValid});
      checkOutput($sformatf("%s c%0d busy", name, c), {{(S*DW-1){1'b0}}, busy}, {{(S*DW-1){1'b0}}, expBusy});
      checkOutput($sformatf("%s c%0d done", name, c), {{(S*DW-1){1'b0}}, done}, {{(S*DW-1){1'b0}}, expDone});
      @(posedge clk);
      #1;
    end
    read_en       = 1'b0;
    read_ifm_size = '0;
    ifm_rdata     = '0;
  endtask

  initial begin
    int doneCnt, busyCnt;
    logic [S-1:0] validSeen;

    rst           = 1'b1;
    read_en       = 1'b0;
    read_ifm_size = '0;
    ifm_rdata     = '0;
    allOnes       = 1'b0;
    clearPlan();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset data", ifm_skew_data, '0);
    checkOutput("reset valid", {{(S*DW-S){1'b0}}, ifm_skew_valid}, '0);
    checkOutput("reset busy", {{(S*DW-1){1'b0}}, busy}, '0);
    checkOutput("reset done", {{(S*DW-1){1'b0}}, done}, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: reset while beats are in flight
    for (int c = 0; c <= 5; c++) begin
      read_en       = 1'b1;
      read_ifm_size = 5'd16;
      ifm_rdata     = (c >= RL) ? rdataFor(c - RL) : {S{16'hDEAD}};
      if (c < 5) begin
        @(posedge clk);
        #1;
      end
    end
    checkOutput("t1 busy before rst", {{(S*DW-1){1'b0}}, busy}, {{(S*DW-1){1'b0}}, 1'b1});
    checkOutput("t1 valid before rst", {{(S*DW-S){1'b0}}, ifm_skew_valid}, {{(S*DW-S){1'b0}}, 16'h000F});
    rst = 1'b1;
    #1;
    checkOutput("t1 data after rst", ifm_skew_data, '0);
    checkOutput("t1 valid after rst", {{(S*DW-S){1'b0}}, ifm_skew_valid}, '0);
    checkOutput("t1 busy after rst", {{(S*DW-1){1'b0}}, busy}, '0);
    checkOutput("t1 done after rst", {{(S*DW-1){1'b0}}, done}, '0);
    read_en   = 1'b0;
    ifm_rdata = '0;
    #1;
    rst = 1'b0;
    doneCnt   = 0;
    busyCnt   = 0;
    validSeen = '0;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk);
      #1;
      doneCnt   += int'(done);
      busyCnt   += int'(busy);
      validSeen |= ifm_skew_valid;
    end
    checkOutput("t1 no done after rst", S*DW'(doneCnt), '0);
    checkOutput("t1 no busy after rst", S*DW'(busyCnt), '0);
    checkOutput("t1 no valid after rst", {{(S*DW-S){1'b0}}, validSeen}, '0);

    // Test 2: 9-beat full-width burst, done expected at cycle RL+9+15
    clearPlan();
    allOnes = 1'b0;
    setBurst(0, 9, 16);
    runPlan("t2", 9 + RL + S + 4);

`ifdef IFM_SKEW_LANE_MASK_EN
    // Test 3: size 5 masks lanes 5..15 while valid stays on all lanes
    clearPlan();
    allOnes = 1'b1;
    setBurst(0, 4, 5);
    runPlan("t3", 4 + RL + S + 4);

    // Test 4: size-16 burst, 2-cycle gap, size-3 burst merge into one done
    clearPlan();
    allOnes = 1'b0;
    setBurst(0, 4, 16);
    setBurst(6, 3, 3);
    runPlan("t4", 9 + RL + S + 4);
`else
    // Test 5: size is ignored without masking
    clearPlan();
    allOnes = 1'b1;
    setBurst(0, 4, 3);
    runPlan("t5", 4 + RL + S + 4);
`endif

    // Out-of-range sizes (0 and 20) behave as full width
    clearPlan();
    allOnes = 1'b0;
    setBurst(0, 2, 0);
    setBurst(4, 2, 20);
    runPlan("clamp", 6 + RL + S + 4);

    // Test 6: single beat walks across all lanes
    clearPlan();
    allOnes = 1'b0;
    setBurst(0, 1, 1);
    runPlan("t6", 1 + RL + S + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
